hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Stall/flush controller that pairs with the EX-stage forwarding unit.
- The forwarding unit handles hazards that bypassing can resolve. This block handles the rest: load-use hazards that need a bubble, taken-branch flushes, and full-pipeline freezes while a multi-cycle data memory access is outstanding.
- Sits beside the hazard/control logic in ID and drives the write-enables and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- REG_ADDR_W, 5, register index width.
- MEM_TIMEOUT, 64, MEM_WAIT cycles before the sticky timeout error is raised; must be >= 2.
- WAIT_CNT_W, 8, wait-counter width; must satisfy 2^WAIT_CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ifid_rs1  in  REG_ADDR_W  rs1 of the instruction in ID.
- ifid_rs2  in  REG_ADDR_W  rs2 of the instruction in ID.
- ifid_use_rs1  in  1  ID instruction reads rs1.
- ifid_use_rs2  in  1  ID instruction reads rs2.
- idex_rd  in  REG_ADDR_W  rd of the instruction in EX.
- idex_memread  in  1  EX instruction is a load.
- branch_taken  in  1  EX resolved a taken branch or jump.
- exmem_memreq  in  1  MEM-stage instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID cleared to NOP.
- idex_write  out  1  ID/EX load enable.
- idex_bubble  out  1  ID/EX loads NOP (control bits zero).
- exmem_write  out  1  EX/MEM load enable.
- memwb_bubble  out  1  MEM/WB loads NOP.
- mem_timeout_err  out  1  sticky: a wait exceeded MEM_TIMEOUT.

Behaviour:
- State register: {RUN, MEM_WAIT}, plus wait_cnt[WAIT_CNT_W-1:0] and the err flag.
- Outputs are combinational from current state and inputs, so a stall takes effect in the same cycle.
- freeze = exmem_memreq && !dmem_ready.
- lu = idex_memread && idex_rd!=0 && ((ifid_use_rs1 && idex_rd==ifid_rs1) || (ifid_use_rs2 && idex_rd==ifid_rs2)).
- Default (no hazard): all *_write=1; all bubble/flush=0.
- Priority 1, freeze (either state): pc_write=ifid_write=idex_write=exmem_write=0, memwb_bubble=1, ifid_flush=0, idex_bubble=0. branch_taken and lu are ignored, because EX/ID are held and both are re-evaluated after the freeze.
- Priority 2, branch_taken && !freeze: ifid_flush=1, idex_bubble=1, pc_write=1. lu is ignored because the ID instruction is squashed.
- Priority 3, lu && !freeze && !branch_taken: pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle. The next cycle the load is in MEM, lu is false, and the forwarding unit supplies the data.
- Transitions:
  - RUN -> MEM_WAIT when freeze; wait_cnt <= 1.
  - MEM_WAIT stays while freeze; wait_cnt increments and saturates at all-ones.
  - MEM_WAIT -> RUN on the cycle dmem_ready=1 (no freeze that cycle, pipeline advances); wait_cnt <= 0.
  - exmem_memreq dropping in MEM_WAIT is also a return to RUN.
- mem_timeout_err: set when in MEM_WAIT and wait_cnt == MEM_TIMEOUT; cleared only by reset. Pipeline keeps waiting.
- Back-to-back memory ops: a new freeze in the cycle after release re-enters MEM_WAIT with wait_cnt=1.
- Reset (synchronous, rst_n=0 at a clk edge, including mid-wait): state=RUN, wait_cnt=0, err=0. Reset has no effect on the combinational outputs that cycle; after reset, outputs follow the default/priority rules with state=RUN.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_lu_stalls, perf_flushes and perf_mem_wait, each 32 bits.
  - Each counts cycles in which the priority-3, priority-2 or priority-1 condition is active.
  - Counters wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - typedef enum logic {RUN, MEM_WAIT} hz_state_t;
  - localparam REG_ADDR_W_DEF=5;
  - the NOP-encoding constant used by the bubble/flush muxes.
- One natural sub-module, hazard_perf_cnt: three saturating-free 32-bit counters instantiated only under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5, ifid_rs1=5, ifid_use_rs1=1 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then defaults. Repeat with idex_rd=0 -> no stall.
- Unused operand: idex_rd=7, ifid_rs2=7, ifid_use_rs2=0 -> no stall.
- Branch over load-use: branch_taken=1 and lu true -> ifid_flush=1, idex_bubble=1, pc_write=1.
- Memory wait: exmem_memreq=1, dmem_ready=0 for 3 cycles, then 1 -> freeze outputs for 3 cycles, state MEM_WAIT, release on cycle 4, wait_cnt back to 0. Assert branch_taken during the wait -> no flush.
- Timeout: MEM_TIMEOUT=4 with dmem_ready held 0 for 6 cycles -> mem_timeout_err rises when wait_cnt reaches 4 and stays high after release, until rst_n=0.
- Reset mid-wait: rst_n=0 during MEM_WAIT -> next edge state=RUN, wait_cnt=0, err=0. With HAZARD_PERF_CNT_EN, all counters read 0 and later match the counted stall, flush and wait cycles.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_pkg: shared state type, default widths and NOP encoding. Rev 1.0
// ----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic {RUN, MEM_WAIT} hz_state_t;

  localparam int REG_ADDR_W_DEF = 5;

  // addi x0, x0, 0 -- what the IF/ID and ID/EX muxes load when bubbled or flushed
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_if: hazard inputs and stage-register controls. Rev 1.0
// ----------------------------------------------------------------------------
interface hazard_stall_ctrl_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
);

  logic [REG_ADDR_W-1:0] ifid_rs1;
  logic [REG_ADDR_W-1:0] ifid_rs2;
  logic                  ifid_use_rs1;
  logic                  ifid_use_rs2;
  logic [REG_ADDR_W-1:0] idex_rd;
  logic                  idex_memread;
  logic                  branch_taken;
  logic                  exmem_memreq;
  logic                  dmem_ready;

  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  idex_write;
  logic                  idex_bubble;
  logic                  exmem_write;
  logic                  memwb_bubble;
  logic                  mem_timeout_err;

  // Pipeline side: supplies hazard information, consumes the controls
  modport master (
    output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
    output idex_rd, idex_memread, branch_taken, exmem_memreq, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
    input  exmem_write, memwb_bubble, mem_timeout_err
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
    input  idex_rd, idex_memread, branch_taken, exmem_memreq, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
    output exmem_write, memwb_bubble, mem_timeout_err
  );

endinterface
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_perf_cnt: wrapping 32-bit cycle counters for stalls, flushes, waits. Rev 1.0
// ----------------------------------------------------------------------------
module hazard_perf_cnt (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        lu_stall,
  input  wire logic        flush,
  input  wire logic        mem_wait,
  output logic      [31:0] lu_cnt,
  output logic      [31:0] flush_cnt,
  output logic      [31:0] wait_cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lu_cnt    <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (lu_stall) lu_cnt    <= lu_cnt + 32'd1;
      if (flush)    flush_cnt <= flush_cnt + 32'd1;
      if (mem_wait) wait_cnt  <= wait_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_stall_ctrl: load-use bubbles, branch flushes, memory-wait freezes. Rev 1.0
// Defining HAZARD_PERF_CNT_EN adds perf_lu_stalls/perf_flushes/perf_mem_wait.
// ----------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = 64,
  parameter int WAIT_CNT_W  = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  hazard_stall_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic       [31:0] perf_lu_stalls,
  output logic       [31:0] perf_flushes,
  output logic       [31:0] perf_mem_wait
`endif
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE     = WAIT_CNT_W'(1);
  localparam logic [WAIT_CNT_W-1:0] CNT_MAX     = '1;

  hz_state_t             state, state_next;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic                  err, err_next;

  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  freeze;
  logic                  lu;
  logic                  flush_act;
  logic                  lu_act;
  logic                  timeout_hit;

  assign ex_rd = hz.idex_rd;

  always_comb begin
    freeze    = hz.exmem_memreq && !hz.dmem_ready;
    lu        = hz.idex_memread && (ex_rd != '0) &&
                ((hz.ifid_use_rs1 && (ex_rd == hz.ifid_rs1)) ||
                 (hz.ifid_use_rs2 && (ex_rd == hz.ifid_rs2)));
    flush_act = hz.branch_taken && !freeze;
    lu_act    = lu && !freeze && !hz.branch_taken;
  end

  // Stage controls; a freeze holds EX/ID so branch and load-use are re-evaluated afterwards
  always_comb begin
    hz.pc_write     = 1'b1;
    hz.ifid_write   = 1'b1;
    hz.ifid_flush   = 1'b0;
    hz.idex_write   = 1'b1;
    hz.idex_bubble  = 1'b0;
    hz.exmem_write  = 1'b1;
    hz.memwb_bubble = 1'b0;
    if (freeze) begin
      hz.pc_write     = 1'b0;
      hz.ifid_write   = 1'b0;
      hz.idex_write   = 1'b0;
      hz.exmem_write  = 1'b0;
      hz.memwb_bubble = 1'b1;
    end else if (flush_act) begin
      hz.ifid_flush   = 1'b1;
      hz.idex_bubble  = 1'b1;
    end else if (lu_act) begin
      hz.pc_write     = 1'b0;
      hz.ifid_write   = 1'b0;
      hz.idex_bubble  = 1'b1;
    end
  end

  assign timeout_hit        = (state == MEM_WAIT) && (wait_cnt == TIMEOUT_CNT);
  assign hz.mem_timeout_err = err || timeout_hit;

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    err_next      = err || timeout_hit;
    unique case (state)
      RUN: begin
        if (freeze) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = CNT_ONE;
        end
      end
      MEM_WAIT: begin
        // Leaving covers both dmem_ready and the request being withdrawn
        if (freeze) begin
          if (wait_cnt != CNT_MAX) wait_cnt_next = wait_cnt + CNT_ONE;
        end else begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      err      <= err_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .lu_stall  (lu_act),
    .flush     (flush_act),
    .mem_wait  (freeze),
    .lu_cnt    (perf_lu_stalls),
    .flush_cnt (perf_flushes),
    .wait_cnt  (perf_mem_wait)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hazard_stall_ctrl: directed checks of hazard_stall_ctrl (MEM_TIMEOUT=4). Rev 1.0
// ----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;
  import hazard_pkg::*;

  // Packed control order: pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble
  localparam logic [6:0] C_DEF    = 7'b1101010;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_FLUSH  = 7'b1111110;
  localparam logic [6:0] C_LU     = 7'b0001110;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   exp_lu = 0;
  int   exp_fl = 0;
  int   exp_mw = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_ADDR_W(5)) hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_stalls;
  logic [31:0] perf_flushes;
  logic [31:0] perf_mem_wait;
`endif

  hazard_stall_ctrl #(
    .REG_ADDR_W  (5),
    .MEM_TIMEOUT (4),
    .WAIT_CNT_W  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_lu_stalls (perf_lu_stalls),
    .perf_flushes   (perf_flushes),
    .perf_mem_wait  (perf_mem_wait)
`endif
  );

  function automatic logic [6:0] ctl();
    return {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_write,
            hz.idex_bubble, hz.exmem_write, hz.memwb_bubble};
  endfunction

  task automatic idle();
    hz.ifid_rs1     = '0;
    hz.ifid_rs2     = '0;
    hz.ifid_use_rs1 = 1'b0;
    hz.ifid_use_rs2 = 1'b0;
    hz.idex_rd      = '0;
    hz.idex_memread = 1'b0;
    hz.branch_taken = 1'b0;
    hz.exmem_memreq = 1'b0;
    hz.dmem_ready   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (dut.state !== RUN) begin fails++; $display("FAIL reset_state got %0d exp %0d", dut.state, RUN); end
    tests++; if (dut.wait_cnt !== 8'd0) begin fails++; $display("FAIL reset_wait_cnt got %0d exp 0", dut.wait_cnt); end
    tests++; if (hz.mem_timeout_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", hz.mem_timeout_err); end
    tests++; if (ctl() !== C_DEF) begin fails++; $display("FAIL reset_ctl got %b exp %b", ctl(), C_DEF); end
    tick();
  endtask

  task automatic test_load_use();
    idle(); hz.idex_memread = 1'b1; hz.idex_rd = 5'd5; hz.ifid_rs1 = 5'd5; hz.ifid_use_rs1 = 1'b1;
    @(negedge clk);
    tests++; if (ctl() !== C_LU) begin fails++; $display("FAIL lu_stall got %b exp %b", ctl(), C_LU); end
    exp_lu++;
    tick();
    idle();
    @(negedge clk);
    tests++; if (ctl() !== C_DEF) begin fails++; $display("FAIL lu_release got %b exp %b", ctl(), C_DEF); end
    tick();
    idle(); hz.idex_memread = 1'b1; hz.idex_rd = 5'd0; hz.ifid_rs1 = 5'd0; hz.ifid_use_rs1 = 1'b1;
    @(negedge clk);
    tests++; if (ctl() !== C_DEF) begin fails++; $display("FAIL lu_rd_zero got %b exp %b", ctl(), C_DEF); end
    tick();
    idle(); hz.idex_memread = 1'b1; hz.idex_rd = 5'd9; hz.ifid_rs1 = 5'd9; hz.ifid_rs2 = 5'd9; hz.ifid_use_rs2 = 1'b1;
    @(negedge clk);
    tests++; if (ctl() !== C_LU) begin fails++; $display("FAIL lu_rs2 got %b exp %b", ctl(), C_LU); end
    exp_lu++;
    tick();
    idle(); hz.idex_rd = 5'd5; hz.ifid_rs1 = 5'd5; hz.ifid_use_rs1 = 1'b1;
    @(negedge clk);
    tests++; if (ctl() !== C_DEF) begin fails++; $display("FAIL lu_not_load got %b exp %b", ctl(), C_DEF); end
    tick();
  endtask

  task automatic test_unused_operand();
    idle(); hz.idex_memread = 1'b1; hz.idex_rd = 5'd7; hz.ifid_rs2 = 5'd7; hz.ifid_use_rs2 = 1'b0;
    hz.ifid_rs1 = 5'd3; hz.ifid_use_rs1 = 1'b1;
    @(negedge clk);
    tests++; if (ctl() !== C_DEF) begin fails++; $display("FAIL unused_rs2 got %b exp %b", ctl(), C_DEF); end
    tick();
  endtask

  task automatic test_branch_over_lu();
    idle(); hz.idex_memread = 1'b1; hz.idex_rd = 5'd5; hz.ifid_rs1 = 5'd5; hz.ifid_use_rs1 = 1'b1;
    hz.branch_taken = 1'b1;
    @(negedge clk);
    tests++; if (ctl() !== C_FLUSH) begin fails++; $display("FAIL branch_over_lu got %b exp %b", ctl(), C_FLUSH); end
    exp_fl++;
    tick();
    idle(); hz.branch_taken = 1'b1;
    @(negedge clk);
    tests++; if (ctl() !== C_FLUSH) begin fails++; $display("FAIL branch_plain got %b exp %b", ctl(), C_FLUSH); end
    tests++; if (dut.state !== RUN) begin fails++; $display("FAIL branch_state got %0d exp %0d", dut.state, RUN); end
    exp_fl++;
    tick();
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      idle(); hz.exmem_memreq = 1'b1; hz.dmem_ready = 1'b0;
      if (i == 1) hz.branch_taken = 1'b1;
      if (i == 2) begin
        hz.idex_memread = 1'b1; hz.idex_rd = 5'd4; hz.ifid_rs1 = 5'd4; hz.ifid_use_rs1 = 1'b1;
      end
      @(negedge clk);
      tests++; if (ctl() !== C_FREEZE) begin fails++; $display("FAIL wait_ctl[%0d] got %b exp %b", i, ctl(), C_FREEZE); end
      if (i > 0) begin
        tests++; if (dut.state !== MEM_WAIT) begin fails++; $display("FAIL wait_state[%0d] got %0d exp %0d", i, dut.state, MEM_WAIT); end
        tests++; if (dut.wait_cnt !== 8'(i)) begin fails++; $display("FAIL wait_cnt[%0d] got %0d exp %0d", i, dut.wait_cnt, i); end
      end
      exp_mw++;
      tick();
    end
    idle(); hz.exmem_memreq = 1'b1; hz.dmem_ready = 1'b1;
    @(negedge clk);
    tests++; if (ctl() !== C_DEF) begin fails++; $display("FAIL wait_release_ctl got %b exp %b", ctl(), C_DEF); end
    tests++; if (dut.wait_cnt !== 8'd3) begin fails++; $display("FAIL wait_release_cnt got %0d exp 3", dut.wait_cnt); end
    tick();
    idle();
    @(negedge clk);
    tests++; if (dut.state !== RUN) begin fails++; $display("FAIL wait_after_state got %0d exp %0d", dut.state, RUN); end
    tests++; if (dut.wait_cnt !== 8'd0) begin fails++; $display("FAIL wait_after_cnt got %0d exp 0", dut.wait_cnt); end
    tests++; if (hz.mem_timeout_err !== 1'b0) begin fails++; $display("FAIL wait_no_err got %b exp 0", hz.mem_timeout_err); end
    tick();
  endtask

  task automatic test_back_to_back();
    idle(); hz.exmem_memreq = 1'b1;
    exp_mw++;
    tick();
    idle(); hz.exmem_memreq = 1'b1; hz.dmem_ready = 1'b1;
    @(negedge clk);
    tests++; if (ctl() !== C_DEF) begin fails++; $display("FAIL b2b_release got %b exp %b", ctl(), C_DEF); end
    tick();
    idle(); hz.exmem_memreq = 1'b1;
    @(negedge clk);
    tests++; if (ctl() !== C_FREEZE) begin fails++; $display("FAIL b2b_refreeze got %b exp %b", ctl(), C_FREEZE); end
    tests++; if (dut.state !== RUN) begin fails++; $display("FAIL b2b_state_run got %0d exp %0d", dut.state, RUN); end
    exp_mw++;
    tick();
    idle();
    @(negedge clk);
    tests++; if (dut.state !== MEM_WAIT) begin fails++; $display("FAIL b2b_state_wait got %0d exp %0d", dut.state, MEM_WAIT); end
    tests++; if (dut.wait_cnt !== 8'd1) begin fails++; $display("FAIL b2b_cnt got %0d exp 1", dut.wait_cnt); end
    tests++; if (ctl() !== C_DEF) begin fails++; $display("FAIL b2b_req_drop got %b exp %b", ctl(), C_DEF); end
    tick();
    @(negedge clk);
    tests++; if (dut.state !== RUN) begin fails++; $display("FAIL b2b_drop_state got %0d exp %0d", dut.state, RUN); end
    tick();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 6; i++) begin
      idle(); hz.exmem_memreq = 1'b1;
      @(negedge clk);
      tests++;
      if (hz.mem_timeout_err !== (i >= 4)) begin
        fails++; $display("FAIL timeout_err[%0d] got %b exp %b", i, hz.mem_timeout_err, (i >= 4));
      end
      exp_mw++;
      tick();
    end
    idle(); hz.exmem_memreq = 1'b1; hz.dmem_ready = 1'b1;
    @(negedge clk);
    tests++; if (dut.wait_cnt !== 8'd6) begin fails++; $display("FAIL timeout_cnt got %0d exp 6", dut.wait_cnt); end
    tests++; if (ctl() !== C_DEF) begin fails++; $display("FAIL timeout_release got %b exp %b", ctl(), C_DEF); end
    tick();
    idle();
    tick();
    @(negedge clk);
    tests++; if (hz.mem_timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_sticky got %b exp 1", hz.mem_timeout_err); end
    tests++; if (dut.state !== RUN) begin fails++; $display("FAIL timeout_state got %0d exp %0d", dut.state, RUN); end
    tick();
  endtask

  task automatic test_perf_counts(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    tests++; if (perf_lu_stalls !== 32'(exp_lu)) begin fails++; $display("FAIL %s_perf_lu got %0d exp %0d", tag, perf_lu_stalls, exp_lu); end
    tests++; if (perf_flushes !== 32'(exp_fl)) begin fails++; $display("FAIL %s_perf_fl got %0d exp %0d", tag, perf_flushes, exp_fl); end
    tests++; if (perf_mem_wait !== 32'(exp_mw)) begin fails++; $display("FAIL %s_perf_mw got %0d exp %0d", tag, perf_mem_wait, exp_mw); end
`else
    $display("[TB] perf counters absent in this build (%s)", tag);
`endif
  endtask

  task automatic test_reset_mid_wait();
    idle(); hz.exmem_memreq = 1'b1;
    tick();
    idle(); hz.exmem_memreq = 1'b1; hz.branch_taken = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if (ctl() !== C_FREEZE) begin fails++; $display("FAIL rstmid_ctl got %b exp %b", ctl(), C_FREEZE); end
    tests++; if (hz.mem_timeout_err !== 1'b1) begin fails++; $display("FAIL rstmid_err_pre got %b exp 1", hz.mem_timeout_err); end
    tick();
    rst_n = 1'b1;
    idle();
    exp_lu = 0; exp_fl = 0; exp_mw = 0;
    @(negedge clk);
    tests++; if (dut.state !== RUN) begin fails++; $display("FAIL rstmid_state got %0d exp %0d", dut.state, RUN); end
    tests++; if (dut.wait_cnt !== 8'd0) begin fails++; $display("FAIL rstmid_cnt got %0d exp 0", dut.wait_cnt); end
    tests++; if (hz.mem_timeout_err !== 1'b0) begin fails++; $display("FAIL rstmid_err got %b exp 0", hz.mem_timeout_err); end
    tests++; if (ctl() !== C_DEF) begin fails++; $display("FAIL rstmid_ctl_after got %b exp %b", ctl(), C_DEF); end
    test_perf_counts("rstmid");
    tick();
    idle(); hz.idex_memread = 1'b1; hz.idex_rd = 5'd12; hz.ifid_rs2 = 5'd12; hz.ifid_use_rs2 = 1'b1;
    exp_lu++;
    tick();
    idle(); hz.branch_taken = 1'b1;
    exp_fl++;
    tick();
    for (int i = 0; i < 2; i++) begin
      idle(); hz.exmem_memreq = 1'b1;
      exp_mw++;
      tick();
    end
    idle(); hz.exmem_memreq = 1'b1; hz.dmem_ready = 1'b1;
    tick();
    idle();
    test_perf_counts("post");
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_unused_operand();
    test_branch_over_lu();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_perf_counts("accum");
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
